bitrev_feeder: RTL
==================

# bitrev_feeder

Streaming input-side reorder buffer for the radix-2 FFT datapath. It accepts complex samples in natural order, one per cycle, and emits each N-sample frame in bit-reversed order. This is the input-ordering counterpart of the output reorder stage: the output stage turns bit-reversed results back into natural order, and this block produces the bit-reversed sequence that the decimation-in-time FFT core consumes. Two frame banks (ping-pong) let frame k+1 be written while frame k is read, so a continuous stream passes with no gaps. Output valid/ready backpressure is supported.

## Interface
Parameters:
- WIDTH, 18, bits per real/imag component (signed two's complement)
- N, 8, frame length; power of two, 4 to 1024
- LOG2N, $clog2(N), address width; derived, never overridden

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- di_re, di_im  in  WIDTH  input sample, natural order
- di_en  in  1  input sample valid
- di_rdy  out  1  write bank free; sample accepted on edge where di_en && di_rdy
- do_re, do_im  out  WIDTH  output sample, bit-reversed order; 0 whenever do_en=0
- do_en  out  1  output valid
- do_rdy  in  1  downstream ready; transfer on edge where do_en && do_rdy
- do_sof  out  1  high with first sample of a frame (valid only with do_en)
- do_eof  out  1  high with last sample of a frame (valid only with do_en)
- ovf  out  1  sticky: di_en seen while di_rdy=0; cleared only by rst

## Operation
- State per bank b∈{0,1}: full[b]. Write side: wr_bank, wr_cnt[LOG2N-1:0]. Read side: rd_bank, rd_cnt.
- di_rdy = !full[wr_bank], combinational from registers.
- Accept: mem[wr_bank][wr_cnt] <= di; wr_cnt++. When wr_cnt==N-1, the same edge sets full[wr_bank], toggles wr_bank, and wraps wr_cnt to 0.
- di_en && !di_rdy: sample dropped, no state change, ovf <= 1.
- Read: the output register loads when (!do_en || do_rdy). If full[rd_bank] then it loads mem[rd_bank][bitrev(rd_cnt)], sets do_en=1, sets do_sof=(rd_cnt==0) and do_eof=(rd_cnt==N-1), and increments rd_cnt. At rd_cnt==N-1 it clears full[rd_bank], toggles rd_bank, and wraps rd_cnt. If not full, it loads zeros and do_en/do_sof/do_eof=0.
- Stall (do_en && !do_rdy): all outputs and rd_cnt hold.
- A set of full[x] and a clear of full[y] on the same edge is legal. x==y cannot occur.
- Reset values: do_re=do_im=0, do_en=do_sof=do_eof=0, ovf=0, full=00, wr_bank=rd_bank=0, counters 0. di_rdy=1 after reset. Memory contents are not reset.
- rst mid-frame discards any partial or pending frames. The first accept after reset starts a new frame at wr_cnt=0.

## Timing
- Latency: the last sample of a frame is accepted at edge k. The first output is registered at edge k+1 and visible in cycle k+1..k+2.
- With do_rdy held at 1 and continuous input: output is 1 sample/cycle with no gap between frames, and di_rdy never deasserts.
- Backpressure: a stalled output frees no bank. Once both banks are full, di_rdy drops in the cycle after the second bank fills. di_rdy returns the cycle after the edge that completes the read of the N-th sample of the bank being drained.
- Memory read is combinational into the output register. Write-then-read of the same address never occurs, because the full handshake prevents it.

## Structure
- Shared FFT package holds a bitrev function parameterised by LOG2N and the default WIDTH/N constants. The output reorder stage uses the same function.
- One sub-module: pingpong_ram. It is 2×N×(2·WIDTH), has one write port and one async read port, and bank select is the address MSB. The top holds the counters, full flags, and output register.

## Test plan
- N=8, one frame with re=i, im=-i (i=0..7), do_rdy=1 → first do_en two cycles after the last accept. Output re sequence is 0,4,2,6,1,5,3,7 with matching im, sof on 0 and eof on 7.
- Four back-to-back frames, do_rdy=1 → 32 contiguous do_en cycles, di_rdy constantly 1, each frame bit-reversed.
- do_rdy=0 throughout, 3 frames offered → 16 accepted, di_rdy low after the second frame, the 17th sample dropped, and ovf=1. Then do_rdy=1 → frames 0 and 1 emerge intact.
- Random do_rdy toggling over 10 frames → outputs hold while stalled, no loss or duplication, and the scoreboard matches bit-reversed order.
- rst asserted after 5 accepts of frame 1 while frame 0 is mid-read → next cycle all outputs 0, di_rdy=1, ovf=0. A fresh frame then reorders correctly.
- N=16, WIDTH=16, extreme values ±(2^15-1)/-2^15 → order is 0,8,4,12,…,15 and values pass through bit-exact.

Source files
------------

// File: rtl/bitrev_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_feeder_pkg
// Purpose  : Shared FFT definitions: default sample width / frame length and
//            the bit-reversal index helper shared by both reorder stages.
// Contents : DEF_WIDTH, DEF_N, MAX_LOG2N, idx_t, bitrev()
// Revision : 1.0 - initial release
// ============================================================================
package bitrev_feeder_pkg;

  localparam int DEF_WIDTH = 18;
  localparam int DEF_N     = 8;
  localparam int MAX_LOG2N = 10;  // largest supported frame is 1024 points

  typedef logic [MAX_LOG2N-1:0] idx_t;

  // Reverse the low nbits bits of idx; bits at and above nbits must be zero.
  // Reversing the full-width index parks the wanted bits in the top nbits
  // positions, so a right shift brings them back down.
  function automatic idx_t bitrev(input idx_t idx, input int nbits);
    idx_t rev;
    rev = {<<{idx}};
    return rev >> (MAX_LOG2N - nbits);
  endfunction

endpackage : bitrev_feeder_pkg
`default_nettype wire

// File: rtl/bitrev_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_feeder_if
// Purpose  : Sample stream bundle around the bit-reversal feeder.
// Signals  : di_re/di_im/di_en -> di_rdy      natural-order input stream
//            do_re/do_im/do_en/do_sof/do_eof <- do_rdy   bit-reversed output
//            ovf                               sticky input overflow flag
// Modports : master - stream source/sink environment, slave - the feeder
// Revision : 1.0 - initial release
// ============================================================================
interface bitrev_feeder_if
  import bitrev_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic             di_en;
  logic             di_rdy;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic             do_en;
  logic             do_rdy;
  logic             do_sof;
  logic             do_eof;
  logic             ovf;

  modport master (
    output di_re, di_im, di_en, do_rdy,
    input  di_rdy, do_re, do_im, do_en, do_sof, do_eof, ovf
  );

  modport slave (
    input  di_re, di_im, di_en, do_rdy,
    output di_rdy, do_re, do_im, do_en, do_sof, do_eof, ovf
  );

endinterface : bitrev_feeder_if
`default_nettype wire

// File: rtl/bitrev_feeder_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_feeder_pingpong_ram
// Purpose  : Two-bank frame store, 2 x N words of {re, im}; one synchronous
//            write port and one asynchronous read port. The address MSB
//            selects the bank. Contents are not reset.
// Ports    : clk, we, waddr, wdata  - write port
//            raddr, rdata           - combinational read port
// Revision : 1.0 - initial release
// ============================================================================
module bitrev_feeder_pingpong_ram #(
  parameter int DW    = 36,
  parameter int LOG2N = 3
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic [LOG2N:0] waddr,
  input  wire logic [DW-1:0] wdata,
  input  wire logic [LOG2N:0] raddr,
  output logic      [DW-1:0] rdata
);

  localparam int DEPTH = 2 << LOG2N;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : bitrev_feeder_pingpong_ram
`default_nettype wire

// File: rtl/bitrev_feeder.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_feeder
// Purpose  : Streaming input reorder buffer for the radix-2 DIT FFT. Accepts
//            natural-order complex samples and emits each N-sample frame in
//            bit-reversed order. Ping-pong banks let one frame be written
//            while the previous one is read; output supports backpressure.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - bitrev_feeder_if.slave (input stream, output stream, ovf)
// Revision : 1.0 - initial release
// ============================================================================
module bitrev_feeder
  import bitrev_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int LOG2N = $clog2(N)
) (
  input wire logic        clk,
  input wire logic        rst,
  bitrev_feeder_if.slave  bus
);

  localparam logic [LOG2N-1:0] C_LAST = LOG2N'(N - 1);

  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [LOG2N-1:0]   r_wr_cnt;
  logic [LOG2N-1:0]   r_rd_cnt;
  logic [WIDTH-1:0]   r_do_re;
  logic [WIDTH-1:0]   r_do_im;
  logic               r_do_en;
  logic               r_do_sof;
  logic               r_do_eof;
  logic               r_ovf;

  logic               w_di_rdy;
  logic               w_accept;
  logic               w_load;
  logic               w_rd_go;
  logic [LOG2N-1:0]   w_rd_idx;
  logic [2*WIDTH-1:0] w_rdata;

  assign w_di_rdy = ~r_full[r_wr_bank];
  assign w_accept = bus.di_en & w_di_rdy;
  // The output register is free when empty or being consumed this edge.
  assign w_load   = ~r_do_en | bus.do_rdy;
  assign w_rd_go  = w_load & r_full[r_rd_bank];
  assign w_rd_idx = LOG2N'(bitrev(idx_t'(r_rd_cnt), LOG2N));

  bitrev_feeder_pingpong_ram #(
    .DW    (2 * WIDTH),
    .LOG2N (LOG2N)
  ) u_ram (
    .clk   (clk),
    .we    (w_accept),
    .waddr ({r_wr_bank, r_wr_cnt}),
    .wdata ({bus.di_re, bus.di_im}),
    .raddr ({r_rd_bank, w_rd_idx}),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_do_re   <= '0;
      r_do_im   <= '0;
      r_do_en   <= 1'b0;
      r_do_sof  <= 1'b0;
      r_do_eof  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      // Write side. Counter wraps naturally because N is a power of two.
      if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (r_wr_cnt == C_LAST) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
        end
      end
      if (bus.di_en && !w_di_rdy) begin
        r_ovf <= 1'b1;
      end

      // Read side. The full handshake guarantees the bank being released
      // here is never the bank the write side marks full on the same edge.
      if (w_load) begin
        if (w_rd_go) begin
          r_do_re  <= w_rdata[2*WIDTH-1:WIDTH];
          r_do_im  <= w_rdata[WIDTH-1:0];
          r_do_en  <= 1'b1;
          r_do_sof <= (r_rd_cnt == '0);
          r_do_eof <= (r_rd_cnt == C_LAST);
          r_rd_cnt <= r_rd_cnt + 1'b1;
          if (r_rd_cnt == C_LAST) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
          end
        end else begin
          r_do_re  <= '0;
          r_do_im  <= '0;
          r_do_en  <= 1'b0;
          r_do_sof <= 1'b0;
          r_do_eof <= 1'b0;
        end
      end
    end
  end

  assign bus.di_rdy = w_di_rdy;
  assign bus.do_re  = r_do_re;
  assign bus.do_im  = r_do_im;
  assign bus.do_en  = r_do_en;
  assign bus.do_sof = r_do_sof;
  assign bus.do_eof = r_do_eof;
  assign bus.ovf    = r_ovf;

endmodule : bitrev_feeder
`default_nettype wire
